sort8_stream_ctrl: RTL and testbench

- Stream front/back end for the 8-input iterative sorting core (`sorting_8`).
- Collects 8 serial 32-bit words over a valid/ready input and presents them in parallel to the core with select high for one cycle.
- Holds select low for the remaining passes, captures the sorted result and drains it serially, largest first, over a valid/ready output.
- Sits directly between the upstream word stream and `sorting_8`, on both its input and output sides.

---
 rtl/sort8_stream_ctrl.sv | 128 ++++++++++++
 tb/tb_sort8_stream_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort8_stream_ctrl.sv
// Serial-to-parallel front end and parallel-to-serial back end for the sorting_8 core.
// Frames of 8 words are loaded, iterated PASSES times, captured and drained largest first.
module sort8_stream_ctrl #(
    parameter int PASSES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [31:0]  out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         srt_sel,
    output logic [255:0] srt_in,
    input  logic [255:0] srt_out,
    output logic         busy
);

    typedef enum logic [2:0] {
        FILL    = 3'd0,
        LOAD    = 3'd1,
        ITER    = 3'd2,
        CAPTURE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  wr_idx_reg, wr_idx_next;
    logic [2:0]  rd_idx_reg, rd_idx_next;
    logic [3:0]  pass_cnt_reg, pass_cnt_next;
    logic [31:0] in_buf_reg  [8];
    logic [31:0] out_buf_reg [8];
    logic        in_fire;
    logic        out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FILL;
            wr_idx_reg   <= 3'd0;
            rd_idx_reg   <= 3'd0;
            pass_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wr_idx_reg   <= wr_idx_next;
            rd_idx_reg   <= rd_idx_next;
            pass_cnt_reg <= pass_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wr_idx_next   = wr_idx_reg;
        rd_idx_next   = rd_idx_reg;
        pass_cnt_next = pass_cnt_reg;
        case (state_reg)
            FILL: begin
                if (in_fire) begin
                    // 3-bit index wraps 7 -> 0 on the last word of the frame
                    wr_idx_next = wr_idx_reg + 3'd1;
                    if (wr_idx_reg == 3'd7) begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                pass_cnt_next = 4'd1;
                state_next    = (PASSES == 1) ? CAPTURE : ITER;
            end
            ITER: begin
                pass_cnt_next = pass_cnt_reg + 4'd1;
                if (pass_cnt_next == 4'(PASSES)) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                rd_idx_next = 3'd0;
                state_next  = DRAIN;
            end
            DRAIN: begin
                if (out_fire) begin
                    rd_idx_next = rd_idx_reg + 3'd1;
                    if (rd_idx_reg == 3'd7) begin
                        state_next = FILL;
                    end
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    in_buf_reg[gi] <= 32'd0;
                end else if (in_fire && (wr_idx_reg == 3'(gi))) begin
                    in_buf_reg[gi] <= in_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_buf_reg[gi] <= 32'd0;
                end else if (state_reg == CAPTURE) begin
                    out_buf_reg[gi] <= srt_out[32*gi +: 32];
                end
            end

            assign srt_in[32*gi +: 32] = rst ? 32'd0 : in_buf_reg[gi];
        end
    endgenerate

    // Outputs are forced quiet while reset is asserted, whatever the state register holds
    assign in_ready  = (state_reg == FILL) && !rst;
    assign out_valid = (state_reg == DRAIN) && !rst;
    assign out_data  = out_valid ? out_buf_reg[rd_idx_reg] : 32'd0;
    assign out_last  = out_valid && (rd_idx_reg == 3'd7);
    assign srt_sel   = (state_reg == LOAD) && !rst;
    assign busy      = (state_reg != FILL) && !rst;

endmodule

// File: tb/tb_sort8_stream_ctrl.sv
// Bench for sort8_stream_ctrl: PASSES=4 and PASSES=1 instances share one stimulus stream,
// each attached to a behavioural model of the sorting_8 core (two odd-even transposition stages per pass).
module tb_sort8_stream_ctrl;

    typedef logic [31:0] word8_t [8];

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         out_ready;

    logic         in_ready4, out_valid4, out_last4, srt_sel4, busy4;
    logic [31:0]  out_data4;
    logic [255:0] srt_in4, srt_out4, s4_reg;

    logic         in_ready1, out_valid1, out_last1, srt_sel1, busy1;
    logic [31:0]  out_data1;
    logic [255:0] srt_in1, srt_out1, s1_reg;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int sel_cnt = 0;
    int rise1 = -1;
    bit prev1 = 0;
    logic [31:0] q1[$];

    sort8_stream_ctrl #(.PASSES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_last(out_last4), .out_ready(out_ready),
        .srt_sel(srt_sel4), .srt_in(srt_in4), .srt_out(srt_out4), .busy(busy4)
    );

    sort8_stream_ctrl #(.PASSES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_last(out_last1), .out_ready(out_ready),
        .srt_sel(srt_sel1), .srt_in(srt_in1), .srt_out(srt_out1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One sorter pass: even-pair then odd-pair compare-exchange, larger value to lower index
    function automatic logic [255:0] srt_pass(input logic [255:0] v);
        logic [31:0] a [8];
        logic [31:0] t;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) a[i] = v[32*i +: 32];
        for (int s = 0; s < 2; s++) begin
            for (int i = s; i < 7; i += 2) begin
                if (a[i] < a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                end
            end
        end
        for (int i = 0; i < 8; i++) r[32*i +: 32] = a[i];
        return r;
    endfunction

    always @(posedge clk) s4_reg <= srt_pass(srt_sel4 ? srt_in4 : s4_reg);
    always @(posedge clk) s1_reg <= srt_pass(srt_sel1 ? srt_in1 : s1_reg);
    assign srt_out4 = s4_reg;
    assign srt_out1 = s1_reg;

    always @(negedge clk) begin
        if (out_valid1 && out_ready) q1.push_back(out_data1);
        if (out_valid1 && !prev1 && rise1 < 0) rise1 = cyc;
        prev1 = out_valid1;
        if (srt_sel4) sel_cnt++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each word lands at rank = #greater + #equal-with-lower-index (descending, stable)
    task automatic model_sort(input word8_t w, output word8_t e);
        for (int i = 0; i < 8; i++) begin
            int rank = 0;
            for (int j = 0; j < 8; j++) begin
                if (w[j] > w[i] || (w[j] == w[i] && j < i)) rank++;
            end
            e[rank] = w[i];
        end
    endtask

    task automatic send_words(input word8_t w, input int n, input bit bubbles, output int e0);
        int k = 0;
        int guard = 0;
        bit acc;
        e0 = -1000;
        while (k < n && guard < 400) begin
            in_valid = bubbles ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data  = in_valid ? w[k] : $urandom;
            @(negedge clk);
            acc = in_valid && in_ready4;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                e0 = cyc;
            end
            guard++;
        end
        in_valid = 1'b0;
        in_data  = 32'd0;
        chk("send_count", k, n);
    endtask

    task automatic drain(input word8_t e, input int stall_at, input int stop_at, output int rise);
        int n = 0;
        int guard = 0;
        int stall = 0;
        bit ir_bad = 0;
        rise = -1;
        while (n < stop_at && guard < 300) begin
            out_ready = !(n == stall_at && stall < 3);
            @(negedge clk);
            if (out_valid4 && rise < 0) rise = cyc;
            if (out_valid4 && in_ready4) ir_bad = 1;
            if (out_valid4 && !out_ready) begin
                stall++;
                chk($sformatf("hold[%0d]", n), out_data4, e[n]);
            end
            if (out_valid4 && out_ready) begin
                chk($sformatf("data[%0d]", n), out_data4, e[n]);
                chk($sformatf("last[%0d]", n), out_last4, (n == 7));
                n++;
            end
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b1;
        chk("drain_count", n, stop_at);
        chk("in_ready_in_drain", ir_bad, 1'b0);
    endtask

    task automatic run_frame(input word8_t w, input bit bubbles, input int stall_at, input string tag);
        word8_t e;
        int e0;
        int rise;
        logic [255:0] p;
        sel_cnt = 0;
        rise1 = -1;
        q1.delete();
        send_words(w, 8, bubbles, e0);
        model_sort(w, e);
        drain(e, stall_at, 8, rise);
        chk({tag, "_latency4"}, rise - e0, 5);
        chk({tag, "_sel_cycles"}, sel_cnt, 1);
        for (int i = 0; i < 8; i++) p[32*i +: 32] = w[i];
        p = srt_pass(p);
        chk({tag, "_p1_count"}, q1.size(), 8);
        for (int i = 0; i < 8 && i < q1.size(); i++) begin
            chk($sformatf("%s_p1[%0d]", tag, i), q1[i], p[32*i +: 32]);
        end
        chk({tag, "_latency1"}, rise1 - e0, 2);
    endtask

    initial begin
        word8_t w;
        word8_t e;
        int e0;
        int rise;
        bit ov_seen;

        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready4, 1'b0);
        chk("rst_out_valid", out_valid4, 1'b0);
        chk("rst_out_last", out_last4, 1'b0);
        chk("rst_out_data", out_data4, 32'd0);
        chk("rst_srt_sel", srt_sel4, 1'b0);
        chk("rst_srt_in", srt_in4, 256'd0);
        chk("rst_busy", busy4, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready4, 1'b1);
        chk("post_rst_busy", busy4, 1'b0);
        @(posedge clk); #1;

        w = '{32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd6, 32'd5, 32'd4};
        run_frame(w, 1'b0, -1, "basic");

        w = '{32'd0, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd5};
        run_frame(w, 1'b0, -1, "extreme");

        w = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
        run_frame(w, 1'b1, 2, "backpressure");

        // Reset after 5 of 8 words: nothing may come out and the next frame must be clean
        w = '{32'd100, 32'd101, 32'd102, 32'd103, 32'd104, 32'd0, 32'd0, 32'd0};
        send_words(w, 5, 1'b0, e0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ov_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid4) ov_seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("caseA_no_output", ov_seen, 1'b0);
        chk("caseA_in_ready", in_ready4, 1'b1);
        w = '{32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2};
        run_frame(w, 1'b0, -1, "caseA");

        // Reset while draining at rd_idx=3
        for (int i = 0; i < 8; i++) w[i] = $urandom;
        send_words(w, 8, 1'b0, e0);
        model_sort(w, e);
        drain(e, -1, 3, rise);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("caseB_valid_in_rst", out_valid4, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("caseB_valid_after", out_valid4, 1'b0);
        chk("caseB_in_ready", in_ready4, 1'b1);
        chk("caseB_busy", busy4, 1'b0);
        @(posedge clk); #1;

        w = '{32'd2, 32'd1, 32'd4, 32'd3, 32'd6, 32'd5, 32'd8, 32'd7};
        run_frame(w, 1'b0, -1, "pass1");

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) begin
                w[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7));
            end
            run_frame(w, ($urandom_range(0, 1) == 1), $urandom_range(0, 8) - 1,
                      $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
